// File: rtl/sw_state_sequencer.sv
// Parametrised switch-driven state sequencer: step up/down with wrap or saturate,
// a step prescaler, a clamped direct-load command and status flags.
module sw_state_sequencer #(
    parameter int STATE_W    = 2,
    parameter int NUM_STATES = 4,
    parameter int DIV        = 1,
    parameter int WRAP       = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         sw,
    input  logic [STATE_W-1:0] load_val,
    output logic [STATE_W-1:0] Q,
    output logic               tick,
    output logic               wrap_pulse,
    output logic               at_min,
    output logic               at_max
);

    typedef enum logic [1:0] {
        CMD_HOLD = 2'b00,
        CMD_UP   = 2'b01,
        CMD_DOWN = 2'b10,
        CMD_LOAD = 2'b11
    } cmd_e;

    localparam int                 CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [STATE_W-1:0] Q_MAX    = STATE_W'(NUM_STATES - 1);
    localparam logic [STATE_W:0]   Q_LIMIT  = (STATE_W + 1)'(NUM_STATES);

    cmd_e               cmd;
    logic [STATE_W-1:0] q_q, q_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wrap_q, wrap_d;
    logic [STATE_W:0]   q_inc, q_dec;

    assign cmd   = cmd_e'(sw);
    assign q_inc = {1'b0, q_q} + (STATE_W + 1)'(1);
    assign q_dec = {1'b0, q_q} - (STATE_W + 1)'(1);
    assign tick  = (cnt_q == CNT_LAST);

    // The extra MSB of q_inc/q_dec flags overflow past the top state or a borrow below zero.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
        case (cmd)
            CMD_LOAD: begin
                cnt_d = '0;
                q_d   = ({1'b0, load_val} < Q_LIMIT) ? load_val : Q_MAX;
            end
            CMD_UP: begin
                if (tick) begin
                    if (q_inc < Q_LIMIT) begin
                        q_d = q_inc[STATE_W-1:0];
                    end else if (WRAP != 0) begin
                        q_d    = '0;
                        wrap_d = 1'b1;
                    end
                end
            end
            CMD_DOWN: begin
                if (tick) begin
                    if (!q_dec[STATE_W]) begin
                        q_d = q_dec[STATE_W-1:0];
                    end else if (WRAP != 0) begin
                        q_d    = Q_MAX;
                        wrap_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign Q          = q_q;
    assign wrap_pulse = wrap_q;
    assign at_min     = (q_q == '0);
    assign at_max     = (q_q == Q_MAX);

endmodule

// File: tb/tb_sw_state_sequencer.sv
// Directed bench for sw_state_sequencer: five instances cover the default
// configuration, saturation, prescaling, load clamping and two-state wrapping.
module tb_sw_state_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [1:0] sw0, sw1, sw2, sw3, sw4;
    logic [1:0] lv0, lv2;
    logic [2:0] lv1, lv3;
    logic [0:0] lv4;

    logic [1:0] q0, q2;
    logic [2:0] q1, q3;
    logic [0:0] q4;
    logic tick0, tick1, tick2, tick3, tick4;
    logic wp0, wp1, wp2, wp3, wp4;
    logic min0, min1, min2, min3, min4;
    logic max0, max1, max2, max3, max4;

    int checks = 0;
    int errors = 0;

    logic [7:0] t1Q   [5]  = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    logic [7:0] t1Wp  [5]  = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd0};
    logic [7:0] t1Max [5]  = '{8'd0, 8'd0, 8'd1, 8'd0, 8'd0};
    logic [7:0] t2Q   [5]  = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
    logic [7:0] t2Wp  [5]  = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    logic [7:0] t2Min [5]  = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd0};
    logic [7:0] t3UpQ [8]  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4};
    logic [7:0] t3Max [8]  = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    logic [7:0] t3DnQ [6]  = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    logic [7:0] t4Q   [10] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd3, 8'd3};
    logic [7:0] t4Tick[10] = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0};
    logic [7:0] t7Q   [4]  = '{8'd1, 8'd0, 8'd1, 8'd0};
    logic [7:0] t7Wp  [4]  = '{8'd0, 8'd1, 8'd0, 8'd1};

    sw_state_sequencer #(.STATE_W(2), .NUM_STATES(4), .DIV(1), .WRAP(1)) dut0 (
        .clk(clk), .reset(reset), .sw(sw0), .load_val(lv0), .Q(q0), .tick(tick0),
        .wrap_pulse(wp0), .at_min(min0), .at_max(max0));

    sw_state_sequencer #(.STATE_W(3), .NUM_STATES(5), .DIV(1), .WRAP(0)) dut1 (
        .clk(clk), .reset(reset), .sw(sw1), .load_val(lv1), .Q(q1), .tick(tick1),
        .wrap_pulse(wp1), .at_min(min1), .at_max(max1));

    sw_state_sequencer #(.STATE_W(2), .NUM_STATES(4), .DIV(3), .WRAP(1)) dut2 (
        .clk(clk), .reset(reset), .sw(sw2), .load_val(lv2), .Q(q2), .tick(tick2),
        .wrap_pulse(wp2), .at_min(min2), .at_max(max2));

    sw_state_sequencer #(.STATE_W(3), .NUM_STATES(5), .DIV(1), .WRAP(1)) dut3 (
        .clk(clk), .reset(reset), .sw(sw3), .load_val(lv3), .Q(q3), .tick(tick3),
        .wrap_pulse(wp3), .at_min(min3), .at_max(max3));

    sw_state_sequencer #(.STATE_W(1), .NUM_STATES(2), .DIV(1), .WRAP(1)) dut4 (
        .clk(clk), .reset(reset), .sw(sw4), .load_val(lv4), .Q(q4), .tick(tick4),
        .wrap_pulse(wp4), .at_min(min4), .at_max(max4));

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drives one instance's command (others hold), then waits past the next edge.
    task automatic applyStimulus(input logic rst, input int unit, input logic [1:0] cmd,
                                 input logic [7:0] val);
        reset = rst;
        sw0 = 2'b00; sw1 = 2'b00; sw2 = 2'b00; sw3 = 2'b00; sw4 = 2'b00;
        case (unit)
            0: begin sw0 = cmd; lv0 = val[1:0]; end
            1: begin sw1 = cmd; lv1 = val[2:0]; end
            2: begin sw2 = cmd; lv2 = val[1:0]; end
            3: begin sw3 = cmd; lv3 = val[2:0]; end
            default: begin sw4 = cmd; lv4 = val[0:0]; end
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        sw0 = 2'b00; sw1 = 2'b00; sw2 = 2'b00; sw3 = 2'b00; sw4 = 2'b00;
        lv0 = '0; lv1 = '0; lv2 = '0; lv3 = '0; lv4 = '0;
        applyStimulus(1'b1, 0, 2'b00, 8'd0);
        applyStimulus(1'b1, 0, 2'b00, 8'd0);
        checkOutput("rst_q0", 8'(q0), 8'd0);
        checkOutput("rst_tick0", 8'(tick0), 8'd1);
        checkOutput("rst_wp0", 8'(wp0), 8'd0);
        checkOutput("rst_min0", 8'(min0), 8'd1);
        checkOutput("rst_max0", 8'(max0), 8'd0);
        checkOutput("rst_tick2", 8'(tick2), 8'd0);
        checkOutput("rst_q1", 8'(q1), 8'd0);

        // Default config counting up through the wrap
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 0, 2'b01, 8'd0);
            checkOutput("t1_q", 8'(q0), t1Q[i]);
            checkOutput("t1_wp", 8'(wp0), t1Wp[i]);
            checkOutput("t1_max", 8'(max0), t1Max[i]);
        end

        applyStimulus(1'b1, 0, 2'b00, 8'd0);
        checkOutput("t2_rst_q", 8'(q0), 8'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 0, 2'b10, 8'd0);
            checkOutput("t2_q", 8'(q0), t2Q[i]);
            checkOutput("t2_wp", 8'(wp0), t2Wp[i]);
            checkOutput("t2_min", 8'(min0), t2Min[i]);
        end

        // Saturating five-state instance
        applyStimulus(1'b1, 0, 2'b00, 8'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1, 2'b01, 8'd0);
            checkOutput("t3_up_q", 8'(q1), t3UpQ[i]);
            checkOutput("t3_max", 8'(max1), t3Max[i]);
            checkOutput("t3_up_wp", 8'(wp1), 8'd0);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1, 2'b10, 8'd0);
            checkOutput("t3_dn_q", 8'(q1), t3DnQ[i]);
            checkOutput("t3_dn_wp", 8'(wp1), 8'd0);
        end
        checkOutput("t3_min", 8'(min1), 8'd1);

        // Prescaled instance, then a mid-count load restarting the prescaler
        applyStimulus(1'b1, 0, 2'b00, 8'd0);
        checkOutput("t4_tick_rst", 8'(tick2), 8'd0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 2, 2'b01, 8'd0);
            checkOutput("t4_q", 8'(q2), t4Q[i]);
            checkOutput("t4_tick", 8'(tick2), t4Tick[i]);
        end
        applyStimulus(1'b0, 2, 2'b11, 8'd2);
        checkOutput("t4_load_q", 8'(q2), 8'd2);
        checkOutput("t4_load_tick", 8'(tick2), 8'd0);
        applyStimulus(1'b0, 2, 2'b00, 8'd0);
        checkOutput("t4_hold1_tick", 8'(tick2), 8'd0);
        applyStimulus(1'b0, 2, 2'b00, 8'd0);
        checkOutput("t4_hold2_tick", 8'(tick2), 8'd1);
        checkOutput("t4_hold2_q", 8'(q2), 8'd2);
        applyStimulus(1'b0, 2, 2'b00, 8'd0);
        checkOutput("t4_hold3_tick", 8'(tick2), 8'd0);
        checkOutput("t4_hold3_q", 8'(q2), 8'd2);

        // Load clamping and wrap_pulse clearing on the wrapping five-state instance
        applyStimulus(1'b1, 0, 2'b00, 8'd0);
        applyStimulus(1'b0, 3, 2'b11, 8'd7);
        checkOutput("t5_clamp_q", 8'(q3), 8'd4);
        checkOutput("t5_clamp_wp", 8'(wp3), 8'd0);
        checkOutput("t5_clamp_max", 8'(max3), 8'd1);
        applyStimulus(1'b0, 3, 2'b01, 8'd0);
        checkOutput("t5_wrap_q", 8'(q3), 8'd0);
        checkOutput("t5_wrap_wp", 8'(wp3), 8'd1);
        applyStimulus(1'b0, 3, 2'b11, 8'd7);
        checkOutput("t5_reload_q", 8'(q3), 8'd4);
        checkOutput("t5_reload_wp", 8'(wp3), 8'd0);
        applyStimulus(1'b0, 3, 2'b11, 8'd3);
        checkOutput("t5_inrange_q", 8'(q3), 8'd3);
        applyStimulus(1'b0, 3, 2'b00, 8'd0);
        checkOutput("t5_hold_q", 8'(q3), 8'd3);

        // Reset mid-sequence overrides a held step command
        applyStimulus(1'b1, 0, 2'b00, 8'd0);
        applyStimulus(1'b0, 0, 2'b01, 8'd0);
        applyStimulus(1'b0, 0, 2'b01, 8'd0);
        checkOutput("t6_pre_q", 8'(q0), 8'd2);
        applyStimulus(1'b1, 0, 2'b01, 8'd0);
        checkOutput("t6_rst_q", 8'(q0), 8'd0);
        checkOutput("t6_rst_wp", 8'(wp0), 8'd0);
        applyStimulus(1'b1, 0, 2'b01, 8'd0);
        checkOutput("t6_rst2_q", 8'(q0), 8'd0);
        applyStimulus(1'b0, 0, 2'b01, 8'd0);
        checkOutput("t6_rel1_q", 8'(q0), 8'd1);
        applyStimulus(1'b0, 0, 2'b01, 8'd0);
        checkOutput("t6_rel2_q", 8'(q0), 8'd2);

        // Two-state instance: every wrap yields its own pulse
        applyStimulus(1'b1, 0, 2'b00, 8'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4, 2'b01, 8'd0);
            checkOutput("t7_q", 8'(q4), t7Q[i]);
            checkOutput("t7_wp", 8'(wp4), t7Wp[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
